// File: rtl/cam_fifo_writer.sv
// Camera byte stream to async-FIFO writer: pairs RGB565 bytes into 16-bit words,
// tracks line/frame completeness and flags words lost to a full FIFO.
module cam_fifo_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk_write,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  pix_data,
    input  logic        fifo_full,
    output logic        fifo_write,
    output logic [15:0] fifo_data_write,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        overflow,
    output logic [9:0]  line_y,
    output logic [15:0] frame_count
);
    // The word counter only has to tell "exactly H_ACTIVE" from anything else,
    // so it saturates one past H_ACTIVE.
    localparam int                WCNT_W      = $clog2(H_ACTIVE + 2);
    localparam logic [WCNT_W-1:0] WCNT_FULL   = WCNT_W'(H_ACTIVE);
    localparam logic [WCNT_W-1:0] WCNT_MAX    = WCNT_W'(H_ACTIVE + 1);
    localparam logic [9:0]        LINE_TARGET = 10'(V_ACTIVE);
    localparam logic [9:0]        LINE_SAT    = 10'd1023;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t            state_q;
    logic              vsync_q;
    logic              href_q;
    logic              phase_q;
    logic              short_q;
    logic [7:0]        hi_byte_q;
    logic [WCNT_W-1:0] word_cnt_q;
    logic              fifo_write_q;
    logic [15:0]       fifo_data_q;
    logic              frame_done_q;
    logic              frame_ok_q;
    logic              overflow_q;
    logic [9:0]        line_y_q;
    logic [15:0]       frame_count_q;

    logic              vsync_rise_s;
    logic              vsync_fall_s;
    logic              line_end_s;
    logic              byte_ovf_s;
    logic              short_end_s;
    logic [9:0]        line_y_end_s;

    // Edge detection and end-of-line results, so a coincident frame end sees the updated line state.
    always_comb begin
        vsync_rise_s = vsync & ~vsync_q;
        vsync_fall_s = ~vsync & vsync_q;
        line_end_s   = (state_q == CAPTURE) && !href && href_q;
        byte_ovf_s   = (state_q == CAPTURE) && href && phase_q && fifo_full;
        if (line_end_s) begin
            line_y_end_s = (line_y_q == LINE_SAT) ? line_y_q : (line_y_q + 10'd1);
            short_end_s  = short_q | (word_cnt_q != WCNT_FULL);
        end else begin
            line_y_end_s = line_y_q;
            short_end_s  = short_q;
        end
    end

    // Capture state machine with registered outputs.
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            phase_q       <= 1'b0;
            short_q       <= 1'b0;
            hi_byte_q     <= 8'h00;
            word_cnt_q    <= '0;
            fifo_write_q  <= 1'b0;
            fifo_data_q   <= 16'h0000;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            overflow_q    <= 1'b0;
            line_y_q      <= 10'd0;
            frame_count_q <= 16'h0000;
        end else begin
            vsync_q      <= vsync;
            href_q       <= href;
            fifo_write_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= WAIT_SOF;
                    end
                    WAIT_SOF: begin
                        if (vsync_fall_s) begin
                            state_q    <= CAPTURE;
                            line_y_q   <= 10'd0;
                            word_cnt_q <= '0;
                            phase_q    <= 1'b0;
                            overflow_q <= 1'b0;
                            short_q    <= 1'b0;
                        end else begin
                            state_q <= WAIT_SOF;
                        end
                    end
                    CAPTURE: begin
                        line_y_q <= line_y_end_s;
                        short_q  <= short_end_s;
                        if (line_end_s) begin
                            word_cnt_q <= '0;
                            phase_q    <= 1'b0;
                        end else if (href) begin
                            phase_q <= ~phase_q;
                            if (!phase_q) begin
                                hi_byte_q <= pix_data;
                            end else if (fifo_full) begin
                                overflow_q <= 1'b1;
                                state_q    <= DROP;
                            end else begin
                                fifo_write_q <= 1'b1;
                                fifo_data_q  <= {hi_byte_q, pix_data};
                                if (word_cnt_q != WCNT_MAX) begin
                                    word_cnt_q <= word_cnt_q + WCNT_W'(1);
                                end
                            end
                        end
                        // Frame end wins over a same-cycle overflow so the frame still closes.
                        if (vsync_rise_s) begin
                            frame_done_q  <= 1'b1;
                            frame_ok_q    <= (line_y_end_s == LINE_TARGET) && !short_end_s
                                             && !(overflow_q || byte_ovf_s);
                            frame_count_q <= frame_count_q + 16'd1;
                            state_q       <= WAIT_SOF;
                        end
                    end
                    DROP: begin
                        if (vsync_rise_s) begin
                            frame_done_q  <= 1'b1;
                            frame_ok_q    <= 1'b0;
                            frame_count_q <= frame_count_q + 16'd1;
                            state_q       <= WAIT_SOF;
                        end else begin
                            state_q <= DROP;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign fifo_write      = fifo_write_q;
    assign fifo_data_write = fifo_data_q;
    assign frame_done      = frame_done_q;
    assign frame_ok        = frame_ok_q;
    assign overflow        = overflow_q;
    assign line_y          = line_y_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_cam_fifo_writer.sv
// Randomized bench for cam_fifo_writer: frames are generated as transactions and the
// expected word stream and frame results are derived from them, then compared each cycle.
module tb_cam_fifo_writer;
    localparam int H = 4;
    localparam int V = 2;

    logic        clk_write = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        vsync;
    logic        href;
    logic [7:0]  pix_data;
    logic        fifo_full;
    logic        fifo_write;
    logic [15:0] fifo_data_write;
    logic        frame_done;
    logic        frame_ok;
    logic        overflow;
    logic [9:0]  line_y;
    logic [15:0] frame_count;

    cam_fifo_writer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_write       (clk_write),
        .rst_n           (rst_n),
        .enable          (enable),
        .vsync           (vsync),
        .href            (href),
        .pix_data        (pix_data),
        .fifo_full       (fifo_full),
        .fifo_write      (fifo_write),
        .fifo_data_write (fifo_data_write),
        .frame_done      (frame_done),
        .frame_ok        (frame_ok),
        .overflow        (overflow),
        .line_y          (line_y),
        .frame_count     (frame_count)
    );

    always #5 clk_write = ~clk_write;

    typedef struct {
        logic [15:0] d;
        int          t;
    } wr_t;

    typedef struct {
        int          t;
        logic        ok;
        logic [9:0]  ly;
        logic [15:0] fc;
        logic        ovf;
    } fd_t;

    wr_t         exp_wr[$];
    fd_t         exp_fd[$];
    logic [15:0] log_wr[$];
    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;
    int          fd_seen = 0;
    int          m_fc = 0;
    logic        last_ok = 1'b0;
    logic        prev_wr = 1'b0;
    int          line_len [0:1099];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(posedge clk_write) edge_n <= edge_n + 1;

    // Compare DUT outputs against the expected transaction queues every cycle.
    always @(negedge clk_write) begin
        wr_t w;
        fd_t f;
        if (!rst_n) begin
            prev_wr = 1'b0;
        end else begin
            if (fifo_write) begin
                log_wr.push_back(fifo_data_write);
                check("write_expected", (exp_wr.size() != 0), 1'b1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    check("wr_data", fifo_data_write, w.d);
                    check("wr_time", edge_n, w.t);
                end
            end
            if (exp_wr.size() != 0 && exp_wr[0].t <= edge_n) begin
                check("write_missing", exp_wr.size(), 0);
                void'(exp_wr.pop_front());
            end
            check("no_back_to_back", (fifo_write && prev_wr), 1'b0);
            prev_wr = fifo_write;
            if (frame_done) begin
                fd_seen++;
                last_ok = frame_ok;
                check("done_expected", (exp_fd.size() != 0), 1'b1);
                if (exp_fd.size() != 0) begin
                    f = exp_fd.pop_front();
                    check("fd_time", edge_n, f.t);
                    check("fd_ok", frame_ok, f.ok);
                    check("fd_line_y", line_y, f.ly);
                    check("fd_count", frame_count, f.fc);
                    check("fd_overflow", overflow, f.ovf);
                end
            end
            if (exp_fd.size() != 0 && exp_fd[0].t <= edge_n) begin
                check("done_missing", exp_fd.size(), 0);
                void'(exp_fd.pop_front());
            end
        end
    end

    function automatic logic rf();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic step(input logic v, input logic h, input logic [7:0] d, input logic f,
                        output int te);
        @(negedge clk_write);
        vsync     = v;
        href      = h;
        pix_data  = d;
        fifo_full = f;
        te        = edge_n + 1;
    endtask

    task automatic idle(input int n);
        int te;
        repeat (n) step(1'b1, 1'b0, 8'h00, 1'b0, te);
    endtask

    // One frame: blanking, vsync fall, nlines lines of line_len[] bytes, vsync rise.
    task automatic run_frame(input int nlines, input int full_word, input bit join_end,
                             input bit rnd_data, input logic [7:0] seed);
        int         te;
        int         lines;
        int         words;
        int         widx;
        bit         dropped;
        bit         shrt;
        logic       f;
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] nb;
        fd_t        fd;
        nb      = seed;
        hi      = 8'h00;
        lines   = 0;
        widx    = 0;
        dropped = 1'b0;
        shrt    = 1'b0;
        step(1'b1, 1'b0, 8'h00, rf(), te);
        step(1'b1, 1'b0, 8'h00, rf(), te);
        step(1'b0, 1'b0, 8'h00, rf(), te);
        for (int l = 0; l < nlines; l++) begin
            words = 0;
            for (int j = 0; j < line_len[l]; j++) begin
                b  = rnd_data ? 8'($urandom) : nb;
                nb = nb + 8'd1;
                if (j % 2 == 0) begin
                    hi = b;
                    step(1'b0, 1'b1, b, rf(), te);
                end else begin
                    f = dropped ? rf() : (widx == full_word);
                    step(1'b0, 1'b1, b, f, te);
                    if (!dropped) begin
                        if (f) begin
                            dropped = 1'b1;
                        end else begin
                            exp_wr.push_back('{d: {hi, b}, t: te});
                            words++;
                        end
                        widx++;
                    end
                end
            end
            if (join_end && l == nlines - 1) begin
                step(1'b1, 1'b0, 8'h00, rf(), te);
            end else begin
                step(1'b0, 1'b0, 8'h00, rf(), te);
            end
            if (!dropped) begin
                lines++;
                if (words != H) shrt = 1'b1;
            end
            if (!(join_end && l == nlines - 1)) begin
                repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00, rf(), te);
            end
        end
        if (!join_end) step(1'b1, 1'b0, 8'h00, rf(), te);
        m_fc   = (m_fc + 1) & 32'hFFFF;
        fd.t   = te;
        fd.ok  = !dropped && (lines == V) && !shrt;
        fd.ly  = (lines > 1023) ? 10'd1023 : 10'(lines);
        fd.fc  = 16'(m_fc);
        fd.ovf = dropped;
        exp_fd.push_back(fd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int te;
        int base_w;
        int base_fd;
        rst_n     = 1'b0;
        enable    = 1'b0;
        vsync     = 1'b0;
        href      = 1'b0;
        pix_data  = 8'h00;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk_write);
        check("rst_fifo_write", fifo_write, 1'b0);
        check("rst_line_y", line_y, 10'd0);
        check("rst_frame_count", frame_count, 16'h0000);
        check("rst_overflow", overflow, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        idle(2);

        // Nominal frame with bytes 0x01..0x10.
        line_len[0] = 8;
        line_len[1] = 8;
        base_w = log_wr.size();
        run_frame(2, -1, 1'b0, 1'b0, 8'h01);
        idle(2);
        #1;
        check("nom_writes", log_wr.size() - base_w, 8);
        check("nom_first", log_wr[base_w], 16'h0102);
        check("nom_last", log_wr[base_w + 7], 16'h0F10);
        check("nom_ok", last_ok, 1'b1);
        check("nom_count", frame_count, 16'd1);

        // FIFO full on the third phase-1 byte.
        base_w = log_wr.size();
        run_frame(2, 2, 1'b0, 1'b1, 8'h00);
        idle(2);
        #1;
        check("ovf_writes", log_wr.size() - base_w, 2);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_ok", last_ok, 1'b0);

        // Odd 7-byte line.
        line_len[0] = 7;
        base_w = log_wr.size();
        run_frame(1, -1, 1'b0, 1'b1, 8'h00);
        idle(2);
        #1;
        check("odd_writes", log_wr.size() - base_w, 3);
        check("odd_ok", last_ok, 1'b0);

        // Enable dropped on a phase-1 byte mid-line.
        base_w  = log_wr.size();
        base_fd = fd_seen;
        step(1'b1, 1'b0, 8'h00, 1'b0, te);
        step(1'b1, 1'b0, 8'h00, 1'b0, te);
        step(1'b0, 1'b0, 8'h00, 1'b0, te);
        step(1'b0, 1'b1, 8'hA1, 1'b0, te);
        step(1'b0, 1'b1, 8'hA2, 1'b0, te);
        exp_wr.push_back('{d: 16'hA1A2, t: te});
        step(1'b0, 1'b1, 8'hA3, 1'b0, te);
        step(1'b0, 1'b1, 8'hA4, 1'b0, te);
        enable = 1'b0;
        repeat (3) step(1'b0, 1'b1, 8'h55, 1'b0, te);
        step(1'b0, 1'b0, 8'h00, 1'b0, te);
        step(1'b1, 1'b0, 8'h00, 1'b0, te);
        step(1'b1, 1'b0, 8'h00, 1'b0, te);
        enable = 1'b1;
        idle(2);
        #1;
        check("endrop_writes", log_wr.size() - base_w, 1);
        check("endrop_no_done", fd_seen - base_fd, 0);

        // Asynchronous reset in the middle of the second line.
        step(1'b1, 1'b0, 8'h00, 1'b0, te);
        step(1'b0, 1'b0, 8'h00, 1'b0, te);
        for (int j = 0; j < 8; j += 2) begin
            step(1'b0, 1'b1, 8'(j + 16), 1'b0, te);
            step(1'b0, 1'b1, 8'(j + 17), 1'b0, te);
            exp_wr.push_back('{d: {8'(j + 16), 8'(j + 17)}, t: te});
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, te);
        step(1'b0, 1'b1, 8'h11, 1'b0, te);
        step(1'b0, 1'b1, 8'h22, 1'b0, te);
        exp_wr.push_back('{d: 16'h1122, t: te});
        step(1'b0, 1'b1, 8'h33, 1'b0, te);
        step(1'b0, 1'b1, 8'h44, 1'b0, te);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fifo_write", fifo_write, 1'b0);
        check("arst_data", fifo_data_write, 16'h0000);
        check("arst_frame_done", frame_done, 1'b0);
        check("arst_frame_ok", frame_ok, 1'b0);
        check("arst_overflow", overflow, 1'b0);
        check("arst_line_y", line_y, 10'd0);
        check("arst_frame_count", frame_count, 16'h0000);
        exp_wr.delete();
        exp_fd.delete();
        m_fc = 0;
        repeat (2) @(negedge clk_write);
        rst_n  = 1'b1;
        base_w = log_wr.size();
        for (int j = 0; j < 12; j++) begin
            step(1'b0, (j % 6 != 5), 8'($urandom), 1'b0, te);
        end
        idle(2);
        #1;
        check("post_rst_no_writes", log_wr.size() - base_w, 0);
        line_len[0] = 8;
        line_len[1] = 8;
        run_frame(2, -1, 1'b0, 1'b1, 8'h00);
        idle(2);
        #1;
        check("post_rst_count", frame_count, 16'd1);

        // line_y saturation with 1030 one-byte lines.
        for (int l = 0; l < 1030; l++) line_len[l] = 1;
        run_frame(1030, -1, 1'b0, 1'b1, 8'h00);
        idle(2);
        #1;
        check("sat_line_y", line_y, 10'd1023);

        // Back-to-back randomized frames.
        for (int k = 0; k < 30; k++) begin
            int nl;
            nl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : V;
            for (int l = 0; l < nl; l++) begin
                line_len[l] = ($urandom_range(0, 9) < 7) ? 2 * H : $urandom_range(1, 11);
            end
            run_frame(nl, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1,
                      $urandom_range(0, 1) == 1, 1'b1, 8'h00);
        end

        // Frame counter wrap from 0xFFFF.
        idle(2);
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        m_fc = 32'hFFFF;
        line_len[0] = 8;
        line_len[1] = 8;
        run_frame(2, -1, 1'b1, 1'b1, 8'h00);
        idle(2);
        #1;
        check("wrap_count", frame_count, 16'h0000);
        check("wrap_ok", last_ok, 1'b1);

        idle(3);
        #1;
        check("writes_drained", exp_wr.size(), 0);
        check("dones_drained", exp_fd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_fifo_writer.md
CAM_FIFO_WRITER -- requirements
Module: cam_fifo_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning 16-bit words per active line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have port clk_write  in  1  clock, the FIFO write-domain clock; all logic is on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  arms capture; sampled only in IDLE, and low in any other state aborts the frame.
REQ-006 SHALL have port vsync  in  1  camera frame sync; high means vertical blanking.
REQ-007 SHALL have port href  in  1  camera line valid; one byte per cycle while high.
REQ-008 SHALL have port pix_data  in  8  camera byte, first byte is the high byte of the RGB565 pair.
REQ-009 SHALL have port fifo_full  in  1  full flag of the write side of the async FIFO.
REQ-010 SHALL have port fifo_write  out  1  registered one-cycle write strobe to the FIFO.
REQ-011 SHALL have port fifo_data_write  out  16  registered word {high byte, low byte}.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse at the end of a captured frame.
REQ-013 SHALL have port frame_ok  out  1  valid with frame_done; high means a complete frame with no overflow.
REQ-014 SHALL have port overflow  out  1  sticky; set when a word is lost to fifo_full, cleared on a frame start.
REQ-015 SHALL have port line_y  out  10  completed-line counter for the current frame.
REQ-016 SHALL have port frame_count  out  16  count of frame_done pulses, wrapping at 2^16.

Function
REQ-017 SHALL register vsync and href once (vsync_q, href_q) and detect edges against those registered copies.
REQ-018 SHALL implement states IDLE, WAIT_SOF, CAPTURE and DROP.
REQ-019 IDLE SHALL go to WAIT_SOF when enable=1, and SHALL otherwise stay in IDLE.
REQ-020 WAIT_SOF SHALL go to CAPTURE on a vsync falling edge, and on that transition SHALL clear line_y, the word counter, the byte phase and overflow.
REQ-021 CAPTURE SHALL toggle the byte phase on each cycle with href=1.
REQ-022 In CAPTURE, a phase-0 byte SHALL be latched as the high byte.
REQ-023 In CAPTURE, on a phase-1 byte with fifo_full=0, the block SHALL assert fifo_write at the next edge with {high byte, pix_data} and increment the word counter.
REQ-024 In CAPTURE, a phase-1 byte with fifo_full=1 SHALL set overflow, SHALL NOT assert fifo_write, and SHALL move the state to DROP.
REQ-025 DROP SHALL suppress all writes and SHALL go to WAIT_SOF on the next vsync rising edge.
REQ-026 On the vsync rising edge, DROP SHALL pulse frame_done with frame_ok=0.
REQ-027 An href falling edge in CAPTURE SHALL increment line_y, clear the word counter, and reset the phase to 0; an odd trailing byte is discarded.
REQ-028 A vsync rising edge in CAPTURE SHALL pulse frame_done for one cycle and go to WAIT_SOF.
REQ-029 frame_ok SHALL be 1 only if line_y==V_ACTIVE, no short line occurred, and overflow=0.
REQ-030 A short line is an href fall with word counter != H_ACTIVE.
REQ-031 Words beyond H_ACTIVE in a line SHALL still be written, and the line SHALL count as short.
REQ-032 line_y SHALL saturate at 1023.
REQ-033 fifo_write SHALL have a latency of 1 cycle from the phase-1 byte sample.
REQ-034 fifo_write SHALL never be high in two consecutive cycles.
REQ-035 Since writes are at least 2 cycles apart, fifo_full sampled on the phase-1 cycle SHALL already reflect the previous write.
REQ-036 enable=0 in WAIT_SOF, CAPTURE or DROP SHALL return the state to IDLE at the next edge, with no frame_done and no further writes; a write already registered SHALL complete.
REQ-037 An href edge and a vsync rising edge in the same cycle SHALL process the line end first, then the frame end, in that one cycle.
REQ-038 frame_count SHALL increment on every frame_done pulse.

Reset
REQ-039 On rst_n=0 the block SHALL enter IDLE immediately, with fifo_write=0, fifo_data_write=0, frame_done=0, frame_ok=0, overflow=0, line_y=0, frame_count=0, phase=0 and vsync_q=href_q=1'b0.
REQ-040 Reset asserted mid-frame SHALL take effect without waiting for a clock, and after release the block SHALL wait for a fresh vsync fall before capturing.

Verification
REQ-041 Nominal frame, H_ACTIVE=4, V_ACTIVE=2, bytes 0x01..0x10 -> 8 writes of 0x0102, 0x0304, ... 0x0F10; frame_done with frame_ok=1; frame_count=1.
REQ-042 fifo_full=1 on the 3rd phase-1 byte -> exactly 2 writes, overflow=1, DROP until vsync rise, frame_done with frame_ok=0.
REQ-043 Line of 7 bytes -> 3 writes, trailing byte dropped, frame_ok=0.
REQ-044 enable dropped mid-line -> no writes from the next cycle on, state IDLE, no frame_done.
REQ-045 rst_n pulsed mid-line -> all outputs 0 asynchronously; re-enable with vsync low and no fall -> no writes until a vsync fall.
REQ-046 Back-to-back frames with bytes every cycle -> fifo_write never high 2 cycles in a row; frame_count wraps from 0xFFFF to 0x0000 on a forced 65536th frame.
